// File: rtl/niosii_tutorial_button_pio_if.sv
// Avalon-MM s1 slave bus of the button PIO.
// Zero wait states; readdata is driven combinationally by the slave.
interface niosii_tutorial_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/niosii_tutorial_button_pio.sv
// Input PIO: 2-flop sync, optional per-bit debounce (BUTTON_PIO_DEBOUNCE_EN),
// sticky edge capture with W1C, maskable level irq. Regs: DATA/DIR/MASK/EDGE.
module niosii_tutorial_button_pio #(
  parameter int DATA_WIDTH      = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  niosii_tutorial_button_pio_if.slave  s1,
  input  logic [DATA_WIDTH-1:0]        in_port,
  output logic                         irq
);
  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t      sync1, sync2, val, prev, irq_mask, edge_capture;
  word_t      ev, clr;
  logic [1:0] arm;
  logic       armed, wr;

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          deb;
    // Debounced bit only follows sync2 after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        deb <= 1'b0;
      end else if (sync2[i] == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign val[i] = deb;
  end
`else
  assign val = sync2;
`endif

  if (EDGE_TYPE == 0) begin : g_rise
    assign ev = val & ~prev;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign ev = ~val & prev;
  end else begin : g_any
    assign ev = val ^ prev;
  end

  assign armed = (arm == 2'd3);
  assign wr    = s1.chipselect && !s1.write_n;
  assign clr   = (wr && s1.address == 2'd3) ? s1.writedata[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
      arm          <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= val;
      if (!armed) arm <= arm + 2'd1;
      if (wr && s1.address == 2'd2) irq_mask <= s1.writedata[DATA_WIDTH-1:0];
      // New events OR in after the clear so a coincident edge is never lost.
      edge_capture <= (edge_capture & ~clr) | (armed ? ev : '0);
    end
  end

  always_comb begin
    s1.readdata = '0;
    case (s1.address)
      2'd0:    s1.readdata[DATA_WIDTH-1:0] = val;
      2'd2:    s1.readdata[DATA_WIDTH-1:0] = irq_mask;
      2'd3:    s1.readdata[DATA_WIDTH-1:0] = edge_capture;
      default: s1.readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);
endmodule
